// File: rtl/bus_mon_pkg.sv
// Shared widths and small helpers for the bus activity monitor.
// Pure declarations; no logic lives here.
package bus_mon_pkg;

  localparam int MID_WIDTH  = 4;
  localparam int WAIT_WIDTH = 8;
  localparam int TXN_WIDTH  = 8;
  localparam int PCT_SCALE  = 100;

  function automatic logic [3:0] popcount12(input logic [11:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

  // Increment that sticks at the largest value representable in 'width' bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] lim;
    lim = (32'd1 << width) - 32'd1;
    return (value >= lim) ? lim : value + 32'd1;
  endfunction

endpackage

// File: rtl/bus_wait_tracker.sv
// Per-master request-to-grant wait counter; the count survives window
// boundaries so a long wait is reported in full when the grant arrives.
module bus_wait_tracker
  import bus_mon_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  grant,
  output logic [WAIT_WIDTH-1:0] wait_cnt,
  output logic                  grant_evt
);

  assign grant_evt = req & grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (req && !grant) begin
      wait_cnt <= WAIT_WIDTH'(sat_inc(32'(wait_cnt), WAIT_WIDTH));
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/bus_activity_monitor.sv
// Passive bus observer: accumulates utilization, transaction count, worst
// grant wait and peak pending requests per window, then snapshots them.
module bus_activity_monitor
  import bus_mon_pkg::*;
#(
  parameter int WINDOW_BITS = 20,
  parameter int NUM_MASTERS = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_reqs,
  input  logic [NUM_MASTERS-1:0] m_grants,
  input  logic                   bus_util,
  input  logic                   clear,
  output logic [6:0]             util_pct,
  output logic [TXN_WIDTH-1:0]   txn_count,
  output logic [WAIT_WIDTH-1:0]  max_wait,
  output logic [MID_WIDTH-1:0]   max_wait_mid,
  output logic [3:0]             peak_pending,
  output logic                   stats_valid
);

  logic [WINDOW_BITS-1:0] win_cnt;
  logic [WINDOW_BITS:0]   busy_acc, busy_next;
  logic [TXN_WIDTH-1:0]   txn_acc, txn_next;
  logic [WAIT_WIDTH-1:0]  max_acc, max_next;
  logic [MID_WIDTH-1:0]   mid_acc, mid_next;
  logic [3:0]             pend_acc, pend_next, pend_now;
  logic                   prev_util;
  logic                   terminal;
  logic [WINDOW_BITS+7:0] busy_ext, pct_prod;
  logic [6:0]             pct_next;

  logic [WAIT_WIDTH-1:0]  wait_cnt [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] grant_evt;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_trk
    bus_wait_tracker u_trk (
      .clk       (clk),
      .rst       (rst),
      .req       (m_reqs[i]),
      .grant     (m_grants[i]),
      .wait_cnt  (wait_cnt[i]),
      .grant_evt (grant_evt[i])
    );
  end

  assign terminal = &win_cnt;

  // Accumulator values including this cycle's events; these are what a
  // terminal edge snapshots, so nothing on the boundary cycle is dropped.
  always_comb begin
    busy_next = busy_acc + (WINDOW_BITS+1)'(bus_util);
    txn_next  = txn_acc;
    if (bus_util && !prev_util) begin
      txn_next = TXN_WIDTH'(sat_inc(32'(txn_acc), TXN_WIDTH));
    end

    // Strict '>' scanning upward keeps the current holder on ties and picks
    // the lowest index among equal simultaneous grants.
    max_next = max_acc;
    mid_next = mid_acc;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_evt[i] && (wait_cnt[i] > max_next)) begin
        max_next = wait_cnt[i];
        mid_next = MID_WIDTH'(i);
      end
    end

    pend_now  = popcount12(12'(m_reqs));
    pend_next = (pend_now > pend_acc) ? pend_now : pend_acc;

    busy_ext = (WINDOW_BITS+8)'(busy_next);
    pct_prod = (busy_ext << 6) + (busy_ext << 5) + (busy_ext << 2);
    pct_next = 7'(pct_prod >> WINDOW_BITS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt      <= '0;
      busy_acc     <= '0;
      txn_acc      <= '0;
      max_acc      <= '0;
      mid_acc      <= '0;
      pend_acc     <= '0;
      prev_util    <= 1'b0;
      util_pct     <= '0;
      txn_count    <= '0;
      max_wait     <= '0;
      max_wait_mid <= '0;
      peak_pending <= '0;
      stats_valid  <= 1'b0;
    end else begin
      prev_util   <= bus_util;
      stats_valid <= 1'b0;
      if (clear) begin
        win_cnt  <= '0;
        busy_acc <= '0;
        txn_acc  <= '0;
        max_acc  <= '0;
        mid_acc  <= '0;
        pend_acc <= '0;
      end else begin
        win_cnt <= win_cnt + WINDOW_BITS'(1);
        if (terminal) begin
          util_pct     <= pct_next;
          txn_count    <= txn_next;
          max_wait     <= max_next;
          max_wait_mid <= mid_next;
          peak_pending <= pend_next;
          stats_valid  <= 1'b1;
          busy_acc     <= '0;
          txn_acc      <= '0;
          max_acc      <= '0;
          mid_acc      <= '0;
          pend_acc     <= '0;
        end else begin
          busy_acc <= busy_next;
          txn_acc  <= txn_next;
          max_acc  <= max_next;
          mid_acc  <= mid_next;
          pend_acc <= pend_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Self-checking bench for bus_activity_monitor with a 16-cycle window:
// table-driven windows feed a scoreboard popped on every stats_valid pulse.
module tb_bus_activity_monitor;

  localparam int WB  = 4;
  localparam int NM  = 12;
  localparam int WIN = 16;

  logic        clk, rst, bus_util, clear;
  logic [11:0] m_reqs, m_grants;
  logic [6:0]  util_pct;
  logic [7:0]  txn_count, max_wait;
  logic [3:0]  max_wait_mid, peak_pending;
  logic        stats_valid;

  bus_activity_monitor #(.WINDOW_BITS(WB), .NUM_MASTERS(NM)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_reqs       (m_reqs),
    .m_grants     (m_grants),
    .bus_util     (bus_util),
    .clear        (clear),
    .util_pct     (util_pct),
    .txn_count    (txn_count),
    .max_wait     (max_wait),
    .max_wait_mid (max_wait_mid),
    .peak_pending (peak_pending),
    .stats_valid  (stats_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One window of stimulus: a bus_util bit pattern, up to two requesters
  // (mid < 0 disables, grant < 0 means still waiting at window end), an
  // optional one-cycle burst of requests, and the expected snapshot.
  typedef struct {
    logic [15:0] util_pat;
    int a_mid; int a_start; int a_grant;
    int b_mid; int b_start; int b_grant;
    logic [11:0] burst; int burst_cyc;
    int e_util; int e_txn; int e_wait; int e_mid; int e_peak;
  } vec_t;

  typedef struct {
    int util; int txn; int max_w; int mid; int peak; int cyc;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;

  function automatic vec_t mkVec(logic [15:0] pat, int am, int as, int ag,
                                 int bm, int bs, int bg, logic [11:0] burst, int bc,
                                 int eu, int et, int ew, int em, int ep);
    vec_t v;
    v.util_pat = pat;
    v.a_mid = am; v.a_start = as; v.a_grant = ag;
    v.b_mid = bm; v.b_start = bs; v.b_grant = bg;
    v.burst = burst; v.burst_cyc = bc;
    v.e_util = eu; v.e_txn = et; v.e_wait = ew; v.e_mid = em; v.e_peak = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, " util_pct"}, int'(util_pct), 0);
    checkOutput({tag, " txn_count"}, int'(txn_count), 0);
    checkOutput({tag, " max_wait"}, int'(max_wait), 0);
    checkOutput({tag, " max_wait_mid"}, int'(max_wait_mid), 0);
    checkOutput({tag, " peak_pending"}, int'(peak_pending), 0);
    checkOutput({tag, " stats_valid"}, int'(stats_valid), 0);
  endtask

  task automatic sampleStats();
    exp_t e;
    if (stats_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected stats_valid: got pulse at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("stats_valid cycle", cyc, e.cyc);
        checkOutput("util_pct", int'(util_pct), e.util);
        checkOutput("txn_count", int'(txn_count), e.txn);
        checkOutput("max_wait", int'(max_wait), e.max_w);
        checkOutput("max_wait_mid", int'(max_wait_mid), e.mid);
        checkOutput("peak_pending", int'(peak_pending), e.peak);
      end
    end
  endtask

  task automatic applyStimulus(input logic u, input logic [11:0] r, input logic [11:0] g,
                               input logic c);
    bus_util = u;
    m_reqs   = r;
    m_grants = g;
    clear    = c;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sampleStats();
  endtask

  task automatic runWindow(input vec_t v);
    exp_t e;
    logic [11:0] r, g;
    e.util = v.e_util; e.txn = v.e_txn; e.max_w = v.e_wait;
    e.mid = v.e_mid; e.peak = v.e_peak; e.cyc = cyc + WIN;
    sb.push_back(e);
    for (int c = 0; c < WIN; c++) begin
      r = '0;
      g = '0;
      if (v.a_mid >= 0 && c >= v.a_start && (v.a_grant < 0 || c <= v.a_grant)) r[v.a_mid] = 1'b1;
      if (v.a_mid >= 0 && c == v.a_grant) g[v.a_mid] = 1'b1;
      if (v.b_mid >= 0 && c >= v.b_start && (v.b_grant < 0 || c <= v.b_grant)) r[v.b_mid] = 1'b1;
      if (v.b_mid >= 0 && c == v.b_grant) g[v.b_mid] = 1'b1;
      if (c == v.burst_cyc) r = r | v.burst;
      applyStimulus(v.util_pat[c], r, g, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus_util = 1'b0;
    clear = 1'b0;
    m_reqs = '0;
    m_grants = '0;
    #1 rst = 1'b1;

    //                pattern    a: mid st gnt  b: mid st gnt burst     bc   util txn wait mid peak
    tbl[0] = mkVec(16'h00FF,    -1, 0,  0,     -1, 0, 0,  12'h000,  -1,   50,  1,  0,  0,  0);
    tbl[1] = mkVec(16'hFFFF,     4, 2,  7,     -1, 0, 0,  12'h000,  -1,  100,  1,  5,  4,  1);
    tbl[2] = mkVec(16'h0E26,     7, 3,  3,     -1, 0, 0,  12'h034,  10,   37,  3,  0,  0,  3);
    tbl[3] = mkVec(16'h8000,     2, 5, 12,     -1, 0, 0,  12'h000,  -1,    6,  1,  7,  2,  1);
    tbl[4] = mkVec(16'h0000,     5, 0,  7,     -1, 0, 0,  12'h000,  -1,    0,  0,  7,  5,  1);
    tbl[5] = mkVec(16'h0001,     9, 0,  4,      3, 2, 6,  12'h000,  -1,    6,  1,  4,  9,  2);
    tbl[6] = mkVec(16'h0000,     6, 0,  5,      1, 0, 5,  12'h000,  -1,    0,  0,  5,  1,  2);

    repeat (2) @(negedge clk);
    checkZeroOutputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      runWindow(tbl[i]);
    end

    // Master 8 waits from cycle 10 across the boundary, granted at cycle 4.
    runWindow(mkVec(16'h0000, 8, 10, -1, -1, 0, 0, 12'h000, -1, 0, 0, 0, 0, 1));
    runWindow(mkVec(16'h0000, 8, 0, 4, -1, 0, 0, 12'h000, -1, 0, 0, 10, 8, 1));

    // Clear at cycle 9 discards the partial window; bus_util stays high into
    // the clear cycle so the next window starts with no rising edge.
    for (int c = 0; c < 9; c++) begin
      applyStimulus(c >= 5, 12'h000, 12'h000, 1'b0);
    end
    applyStimulus(1'b1, 12'h000, 12'h000, 1'b1);
    runWindow(mkVec(16'h0003, -1, 0, 0, -1, 0, 0, 12'h000, -1, 12, 0, 0, 0, 0));

    // Held clear suppresses snapshots while master 11 waits 300 cycles.
    repeat (300) applyStimulus(1'b0, 12'h800, 12'h000, 1'b1);
    runWindow(mkVec(16'h0000, 11, 0, 0, -1, 0, 0, 12'h000, -1, 0, 0, 255, 11, 1));

    runWindow(tbl[1]);

    // Reset mid-window with bus_util and a request still active.
    repeat (6) applyStimulus(1'b1, 12'h008, 12'h000, 1'b0);
    rst = 1'b1;
    #1;
    checkZeroOutputs("mid-window reset");
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    runWindow(mkVec(16'h0FFF, 3, 0, 2, -1, 0, 0, 12'h000, -1, 75, 1, 2, 3, 1));

    checkOutput("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
